mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one port of the dual-port exmem (16-bit data, 10-bit address) between two requesters: requester 0 (CPU datapath) and requester 1 (display/board-scan reader).
- Valid/ready handshake per requester, registered memory command, read-data return tagged to the issuing requester.
- Sits between the requesters and exmem port 1; exmem port 2 stays free for other logic.

Parameters:
- DATA_W, 16, data width of exmem.
- ADDR_W, 10, address width of exmem.
- READ_LAT, 1, exmem cycles from registered address to valid dout; legal values are 1 or 2.
- STARVE_LIMIT, 4, consecutive denied cycles after which requester 1 wins the next contention; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request valid, one per requester.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  access address.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  ready; combinational; the access transfers when reqX && gntX at the rising clk edge.
- rvalid0 / rvalid1  out  1  one-cycle pulse; rdataX is valid.
- rdata0 / rdata1  out  DATA_W  read data; both driven from mem_dout.
- mem_addr  out  ADDR_W  to exmem addr.
- mem_din  out  DATA_W  to exmem din.
- mem_wen  out  1  to exmem wen.
- mem_dout  in  DATA_W  from exmem dout.

Behaviour:
- Reset (reset=0, asynchronous): mem_addr=0, mem_din=0, mem_wen=0, rvalid0/1=0, owner=OWN_NONE, starvation counter=0, read pipeline cleared.
  - In-flight reads are dropped; no rvalid is produced for them after reset is released.
- Grant (combinational, evaluated every cycle):
  - At most one of gnt0/gnt1 is high in any cycle.
  - gntX may only be high when reqX is high.
  - Only req0: gnt0. Only req1: gnt1.
  - Both requesting: gnt0, unless starve_cnt == STARVE_LIMIT, in which case gnt1.
- Starvation counter (4 bits):
  - Increments when req1 && !gnt1, saturating at STARVE_LIMIT.
  - Clears to 0 on gnt1 or when req1 is low.
- Owner FSM: states OWN_NONE, OWN0, OWN1.
  - Next state = OWN0 on an accepted req0, OWN1 on an accepted req1, OWN_NONE when nothing is accepted.
  - The FSM is used by the optional feature and drives the tag for the read pipeline.
- Command stage:
  - On an accepted transfer, register addr/wdata/we of the winner into mem_addr/mem_din/mem_wen.
  - The command is therefore visible to exmem in cycle t+1, where t is the accept cycle.
  - With no accept, mem_wen=0 the next cycle; mem_addr and mem_din hold their previous values.
- Throughput: one access per cycle, back-to-back, with no bubbles.
- Read return:
  - An accepted read pushes {valid, owner} into a READ_LAT+1 deep shift pipeline.
  - rvalidX pulses in cycle t+1+READ_LAT, with rdataX = mem_dout.
  - Writes produce no rvalid.
  - Returns arrive in issue order.
- Ordering: accesses reach exmem in accept order.
  - A read accepted in the cycle after a write to the same address returns the newly written data.
- Requester obligation: hold addr, we and wdata stable while reqX is high and gntX is low.
  - The arbiter does not check this.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: on contention, grant the requester not recorded in the owner FSM; OWN_NONE favours requester 0. The starvation counter is not instantiated.
- Undefined: fixed priority plus starvation limit, as specified under Behaviour.

Decomposition:
- Package mem_arb_pkg:
  - owner_t enum {OWN_NONE, OWN0, OWN1}.
  - Constants MEM_DATA_W=16 and MEM_ADDR_W=10, shared with exmem users.
- Sub-module rd_return_pipe: the parameterised-depth valid/tag shift register that generates rvalid0/rvalid1.
- Arbitration logic and command register stay in the top module.

Test Plan:
- Solo write then read: req0 writes 16'h0004 to 10'h000 (accept t), then req0 reads 10'h000 at t+1 -> mem_wen=1 in t+1; rvalid0 at t+3 (READ_LAT=1) with rdata0=16'h0004; rvalid1 never asserts.
- Contention, default build: req0 and req1 held continuously reading 10'h001, STARVE_LIMIT=4 -> gnt0 for 4 cycles, then gnt1 for 1 cycle, then the pattern repeats; gnt0 and gnt1 are never high together.
- Contention with MEM_ARB_RR_EN: same stimulus -> gnt alternates 0,1,0,1 starting with gnt0.
- Back-to-back mixed traffic: req1 writes 16'h0002 to 10'h001 at cycle t, req0 reads 10'h001 at t+1 -> rdata0=16'h0002 with rvalid0 at t+3.
- Reset mid-operation: read accepted at t, reset asserted at t+1 for one cycle -> no rvalid pulse afterwards; mem_wen=0 immediately on reset assertion.
- READ_LAT=2 build: single read accepted at t -> rvalid at t+3 only; the rdata seen at t+2 is ignored.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and exmem geometry for the exmem port-1 arbiter.
package mem_arb_pkg;

  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 10;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN0     = 2'd1,
    OWN1     = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_rd_return_pipe.sv
// Valid/owner-tag shift register: a read pushed at its accept edge emerges
// DEPTH cycles later as a one-cycle rvalid pulse for the tagged requester.
module rd_return_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  owner_t tag,
  output logic   rvalid0,
  output logic   rvalid1
);

  logic [DEPTH-1:0] vld;
  owner_t           tag_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= OWN_NONE;
    end else begin
      vld[0]   <= push;
      tag_q[0] <= tag;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i]   <= vld[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign rvalid0 = vld[DEPTH-1] && (tag_q[DEPTH-1] == OWN0);
  assign rvalid1 = vld[DEPTH-1] && (tag_q[DEPTH-1] == OWN1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for exmem port 1 with registered command and tagged
// read return. Define MEM_ARB_RR_EN for round-robin contention handling.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W       = MEM_DATA_W,
  parameter int ADDR_W       = MEM_ADDR_W,
  parameter int READ_LAT     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_dout,
  output owner_t            dbg_owner
);

  // Handshake: a request transfers at the rising edge where reqX && gntX.
  // gntX is combinational and never high without reqX; the requester must
  // hold addr/we/wdata stable while reqX is high and gntX is low.

  owner_t owner, owner_nxt;
  logic   acc0, acc1, rd_push;

`ifdef MEM_ARB_RR_EN
  // Contention goes to whoever did not win last cycle; idle favours 0.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (owner == OWN0) gnt1 = 1'b1;
      else               gnt0 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (starve_cnt == STARVE_MAX) gnt1 = 1'b1;
      else                          gnt0 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // Counts consecutive denied cycles of requester 1, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (!req1 || gnt1) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  assign acc0 = req0 && gnt0;
  assign acc1 = req1 && gnt1;

  always_comb begin
    owner_nxt = OWN_NONE;
    if (acc0)      owner_nxt = OWN0;
    else if (acc1) owner_nxt = OWN1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) owner <= OWN_NONE;
    else        owner <= owner_nxt;
  end

  assign dbg_owner = owner;

  // Address and data hold when idle; only the write enable is pulsed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr <= '0;
      mem_din  <= '0;
      mem_wen  <= 1'b0;
    end else begin
      mem_wen <= 1'b0;
      if (acc0) begin
        mem_addr <= addr0;
        mem_din  <= wdata0;
        mem_wen  <= we0;
      end else if (acc1) begin
        mem_addr <= addr1;
        mem_din  <= wdata1;
        mem_wen  <= we1;
      end
    end
  end

  assign rd_push = (acc0 && !we0) || (acc1 && !we1);

  rd_return_pipe #(
    .DEPTH (READ_LAT + 1)
  ) u_rd_return_pipe (
    .clk     (clk),
    .reset   (reset),
    .push    (rd_push),
    .tag     (owner_nxt),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1)
  );

  assign rdata0 = mem_dout;
  assign rdata1 = mem_dout;

endmodule
